// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator adder sequencer.
package calc_pkg;

    localparam int unsigned CALC_N = 8;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_RSV = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

endpackage

// File: rtl/eight_bit_adder.sv
// N-bit ripple-carry adder built from one_bit_adder cells.
module eight_bit_adder #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_cin,
    output logic [N-1:0] o_sum,
    output logic         o_cout
);

    // Carry kept per generate block so the chain is not one self-dependent vector.
    for (genvar gi = 0; gi < N; gi++) begin : g_bit
        logic w_cin;
        logic w_cout;

        if (gi == 0) begin : g_lsb
            assign w_cin = i_cin;
        end else begin : g_upper
            assign w_cin = g_bit[gi-1].w_cout;
        end

        one_bit_adder u_fa (
            .i_a    (i_a[gi]),
            .i_b    (i_b[gi]),
            .i_cin  (w_cin),
            .o_sum  (o_sum[gi]),
            .o_cout (w_cout)
        );
    end

    assign o_cout = g_bit[N-1].w_cout;

endmodule

// File: rtl/one_bit_adder.sv
// Single-bit full adder cell used to build the ripple adder.
module one_bit_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/calc_adder_sequencer.sv
// Drives one shared ripple adder to perform ADD, SUB and shift-and-add MUL
// between a valid/ready operand front end and a valid/ready result consumer.
module calc_adder_sequencer
    import calc_pkg::*;
#(
    parameter int unsigned N = CALC_N
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [1:0]     op,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] result,
    output logic           err
);

    localparam int unsigned CNT_W = $clog2(N) + 1;

    state_t           r_state;
    op_t              r_op;
    logic [N-1:0]     r_a;
    logic [N-1:0]     r_b;
    logic [N-1:0]     r_p_hi;
    logic [N-1:0]     r_p_lo;
    logic [CNT_W-1:0] r_cnt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_err;
    logic [2*N-1:0]   r_result;

    logic [N-1:0]     w_add_a;
    logic [N-1:0]     w_add_b;
    logic             w_cin;
    logic [N-1:0]     w_sum;
    logic             w_cout;
    logic [2*N-1:0]   w_mul_next;
    logic             w_mul_last;

    always_comb begin
        w_add_a = '0;
        w_add_b = '0;
        w_cin   = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_add_a = r_a;
                w_add_b = r_b;
            end
            OP_SUB: begin
                w_add_a = r_a;
                w_add_b = ~r_b;
                w_cin   = 1'b1;
            end
            OP_MUL: begin
                w_add_a = r_p_hi;
                w_add_b = r_p_lo[0] ? r_a : '0;
            end
            default: ;
        endcase
    end

    eight_bit_adder #(
        .N (N)
    ) u_adder (
        .i_a    (w_add_a),
        .i_b    (w_add_b),
        .i_cin  (w_cin),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // One shift-and-add step: new high half is the adder output, low half shifts right.
    assign w_mul_next = {w_cout, w_sum, r_p_lo[N-1:1]};
    assign w_mul_last = (r_cnt == CNT_W'(N - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_op        <= OP_ADD;
            r_a         <= '0;
            r_b         <= '0;
            r_p_hi      <= '0;
            r_p_lo      <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            r_result    <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_op       <= op_t'(op);
                        r_a        <= a;
                        r_b        <= b;
                        r_p_hi     <= '0;
                        r_p_lo     <= b;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= EXEC;
                    end
                end
                EXEC: begin
                    if (r_op == OP_MUL) begin
                        {r_p_hi, r_p_lo} <= w_mul_next;
                        r_cnt            <= r_cnt + CNT_W'(1);
                        if (w_mul_last) begin
                            r_result    <= w_mul_next;
                            r_err       <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end
                    end else begin
                        r_result    <= (r_op == OP_RSV) ? '0 : {{(N-1){1'b0}}, w_cout, w_sum};
                        r_err       <= (r_op == OP_RSV);
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign err       = r_err;

endmodule
